riscv_fetch_unit: RTL and testbench

- Parametrised instruction-fetch stage for the RISC-V pipeline, replacing the fixed 8-bit-PC fetch in front of decode.
- Owns the PC and drives a synchronous instruction memory with one-cycle read latency.
- Buffers returned instructions in a prefetch FIFO and hands them to decode over a valid/ready handshake.
- Supports a fetch enable, taken-branch/jump redirect with flush, and PC wrap-around.

---
 rtl/riscv_fetch_unit.sv | 133 +++++++++++++
 tb/tb_riscv_fetch_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_unit.sv
// rtl/riscv_fetch_unit.sv - instruction fetch stage with prefetch FIFO, redirect/flush and PC wrap
module riscv_fetch_unit #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int RESET_PC   = 0,
   parameter int PC_STEP    = 4
) (
   input  logic              clk,
   input  logic              res_n,
   input  logic              fetch_en,
   output logic [ADDR_W-1:0] i_addr,
   output logic              i_req,
   input  logic [DATA_W-1:0] i_datain,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [DATA_W-1:0] if_instr,
   output logic [ADDR_W-1:0] if_pc,
   output logic              fifo_full
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);
   localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(PC_STEP - 1);
   localparam logic [ADDR_W-1:0] RST_PC   = ADDR_W'(RESET_PC);
   localparam logic [CNT_W:0]    OCC_MAX  = (CNT_W + 1)'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
   logic              inflight_q, inflight_d;
   logic              kill_q, kill_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [DATA_W-1:0] instr_mem_q [FIFO_DEPTH];
   logic [ADDR_W-1:0] pc_mem_q    [FIFO_DEPTH];

   logic [CNT_W:0] occupancy;
   logic           issue;
   logic           push;
   logic           pop;

   // Reserve a slot for the in-flight response so the FIFO can never overflow.
   assign occupancy = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
   assign issue     = (state_q == S_RUN) && fetch_en && (occupancy < OCC_MAX);
   assign push      = inflight_q && !kill_q && !redirect;
   assign pop       = if_valid && if_ready;

   assign i_addr    = pc_q;
   assign i_req     = issue;
   assign if_valid  = (count_q != '0);
   assign if_instr  = instr_mem_q[rd_ptr_q];
   assign if_pc     = pc_mem_q[rd_ptr_q];
   assign fifo_full = (count_q == CNT_MAX);

   always_comb begin
      state_d = S_IDLE;
      case (state_q)
         S_IDLE:  state_d = fetch_en ? S_RUN : S_IDLE;
         S_RUN:   state_d = fetch_en ? S_RUN : S_IDLE;
         S_FLUSH: state_d = fetch_en ? S_RUN : S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (redirect) state_d = S_FLUSH;
   end

   always_comb begin
      pc_d       = pc_q;
      rsp_pc_d   = rsp_pc_q;
      inflight_d = issue;
      kill_d     = redirect;
      if (issue) begin
         pc_d     = pc_q + STEP;
         rsp_pc_d = pc_q;
      end
      if (redirect) pc_d = redirect_pc & ~LOW_MASK;
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (redirect) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q    <= S_IDLE;
         pc_q       <= RST_PC;
         rsp_pc_q   <= RST_PC;
         inflight_q <= 1'b0;
         kill_q     <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         rsp_pc_q   <= rsp_pc_d;
         inflight_q <= inflight_d;
         kill_q     <= kill_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Storage needs no reset: an empty count hides any stale entries.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem_q[wr_ptr_q] <= i_datain;
         pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
      end
   end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb/tb_riscv_fetch_unit.sv - directed and randomized bench for riscv_fetch_unit
module tb_riscv_fetch_unit;

   logic        clk = 1'b0;
   logic        res_n;
   logic        fetch_en;
   logic [7:0]  i_addr;
   logic        i_req;
   logic [31:0] i_datain;
   logic        redirect;
   logic [7:0]  redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [7:0]  if_pc;
   logic        fifo_full;

   always #5 clk = ~clk;

   riscv_fetch_unit dut (
      .clk(clk), .res_n(res_n), .fetch_en(fetch_en),
      .i_addr(i_addr), .i_req(i_req), .i_datain(i_datain),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_ready(if_ready),
      .if_instr(if_instr), .if_pc(if_pc), .fifo_full(fifo_full)
   );

   logic [31:0] mem [256];

   always @(posedge clk) if (i_req) i_datain <= mem[i_addr];

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;

   logic [7:0]  iss_a [$];
   int          iss_t [$];
   logic [7:0]  del_pc [$];
   logic [31:0] del_in [$];
   int          del_t [$];

   logic [7:0]  exp_iss, exp_del;
   logic        p_hold;
   logic [7:0]  p_pc;
   logic [31:0] p_instr;
   logic        s_req, s_valid, s_full;
   logic [7:0]  s_addr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic clear_model();
      iss_a.delete(); iss_t.delete();
      del_pc.delete(); del_in.delete(); del_t.delete();
      exp_iss = 8'h00;
      exp_del = 8'h00;
      p_hold  = 1'b0;
   endtask

   // One cycle: sample mid-cycle, check against the stream model, advance past the edge.
   task automatic step();
      @(negedge clk);
      s_req = i_req; s_addr = i_addr; s_valid = if_valid; s_full = fifo_full;
      if (p_hold) begin
         check("hold_valid", if_valid, 1);
         check("hold_pc", if_pc, p_pc);
         check("hold_instr", if_instr, p_instr);
      end
      if (i_req) begin
         check("iss_addr", i_addr, exp_iss);
         iss_a.push_back(i_addr); iss_t.push_back(cyc_n);
         exp_iss = exp_iss + 8'd4;
      end
      if (if_valid && if_ready) begin
         check("del_pc", if_pc, exp_del);
         check("del_instr", if_instr, mem[if_pc]);
         del_pc.push_back(if_pc); del_in.push_back(if_instr); del_t.push_back(cyc_n);
         exp_del = exp_del + 8'd4;
      end
      if (redirect) begin
         exp_iss = redirect_pc & 8'hFC;
         exp_del = redirect_pc & 8'hFC;
      end
      p_hold  = if_valid && !if_ready && !redirect;
      p_pc    = if_pc;
      p_instr = if_instr;
      cyc_n++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic fe, input logic rdy);
      res_n = 1'b0; fetch_en = 1'b0; if_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
      @(posedge clk);
      #1;
      check("rst_i_req", i_req, 0);
      check("rst_if_valid", if_valid, 0);
      check("rst_i_addr", i_addr, 0);
      check("rst_fifo_full", fifo_full, 0);
      clear_model();
      fetch_en = fe; if_ready = rdy;
      res_n = 1'b1;
   endtask

   task automatic wait_issue(input logic [7:0] a, input string tag);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!(s_req && s_addr == a) && n < 40);
      if (!(s_req && s_addr == a)) check(tag, 0, 1);
   endtask

   initial begin
      logic [7:0] wrapv [4];
      int n_i, n_d, found, n;
      wrapv[0] = 8'hF8; wrapv[1] = 8'hFC; wrapv[2] = 8'h00; wrapv[3] = 8'h04;
      for (int i = 0; i < 256; i++) mem[i] = 32'(i);
      res_n = 1'b0;
      #1;
      check("rst_async_valid", if_valid, 0);

      // Streaming from reset
      do_reset(1'b1, 1'b1);
      repeat (10) step();
      check("t1_n_iss", iss_a.size() >= 3, 1);
      check("t1_n_del", del_pc.size() >= 3, 1);
      if (iss_a.size() >= 3 && del_pc.size() >= 3) begin
         check("t1_a0", iss_a[0], 8'h00);
         check("t1_a1", iss_a[1], 8'h04);
         check("t1_a2", iss_a[2], 8'h08);
         check("t1_a_consec", iss_t[2] - iss_t[0], 2);
         check("t1_latency", del_t[0] - iss_t[0], 2);
         check("t1_pc0", del_pc[0], 8'h00);
         check("t1_instr0", del_in[0], 32'h0);
         check("t1_thruput", del_t[2] - del_t[0], 2);
      end

      // Backpressure from the start
      do_reset(1'b1, 1'b0);
      repeat (12) step();
      check("t2_n_iss", iss_a.size(), 4);
      if (iss_a.size() >= 4) check("t2_last_iss", iss_a[3], 8'h0C);
      check("t2_full", s_full, 1);
      check("t2_req_stopped", s_req, 0);
      check("t2_no_del", del_pc.size(), 0);
      if_ready = 1'b1;
      repeat (8) step();
      check("t2_n_del", del_pc.size() >= 4, 1);
      if (del_pc.size() >= 4) begin
         for (int i = 0; i < 4; i++) check("t2_drain", del_pc[i], 8'(4 * i));
      end
      if (iss_a.size() >= 5) check("t2_resume", iss_a[4], 8'h10);
      else check("t2_resume_cnt", iss_a.size(), 5);

      // Redirect while 0x10 is in flight
      do_reset(1'b1, 1'b1);
      wait_issue(8'h10, "t3_timeout");
      redirect = 1'b1; redirect_pc = 8'h43;
      step();
      redirect = 1'b0;
      n_d = del_pc.size();
      step();
      check("t3_flush_req", s_req, 0);
      check("t3_flush_empty", s_valid, 0);
      step();
      check("t3_target_req", s_req, 1);
      check("t3_target_addr", s_addr, 8'h40);
      repeat (4) step();
      if (del_pc.size() > n_d) check("t3_first_pc", del_pc[n_d], 8'h40);
      else check("t3_del_cnt", del_pc.size() > n_d, 1);
      found = 0;
      foreach (del_pc[i]) if (del_pc[i] == 8'h10) found++;
      check("t3_dropped", found, 0);

      // PC wrap-around
      redirect = 1'b1; redirect_pc = 8'hF8;
      step();
      redirect = 1'b0;
      n_i = iss_a.size(); n_d = del_pc.size();
      repeat (10) step();
      if (iss_a.size() >= n_i + 4 && del_pc.size() >= n_d + 4) begin
         for (int i = 0; i < 4; i++) begin
            check("t4_iss_wrap", iss_a[n_i + i], wrapv[i]);
            check("t4_pc_wrap", del_pc[n_d + i], wrapv[i]);
         end
      end else check("t4_counts", 0, 1);

      // fetch_en dropped after issuing 0x08
      do_reset(1'b1, 1'b1);
      wait_issue(8'h08, "t5_timeout");
      fetch_en = 1'b0;
      repeat (6) step();
      check("t5_n_iss", iss_a.size(), 3);
      check("t5_n_del", del_pc.size(), 3);
      if (del_pc.size() == 3) check("t5_last_del", del_pc[2], 8'h08);
      fetch_en = 1'b1;
      n_i = iss_a.size();
      repeat (4) step();
      if (iss_a.size() > n_i) check("t5_resume", iss_a[n_i], 8'h0C);
      else check("t5_resume_cnt", 0, 1);

      // Asynchronous reset with three buffered entries
      do_reset(1'b1, 1'b0);
      n = 0;
      while (iss_a.size() < 3 && n < 40) begin step(); n++; end
      check("t6_filled", iss_a.size(), 3);
      fetch_en = 1'b0;
      step(); step();
      check("t6_valid_before", s_valid, 1);
      #2 res_n = 1'b0;
      #1;
      check("t6_async_valid", if_valid, 0);
      check("t6_async_addr", i_addr, 0);
      check("t6_async_req", i_req, 0);
      @(posedge clk);
      #1;
      clear_model();
      fetch_en = 1'b1; if_ready = 1'b1;
      res_n = 1'b1;
      repeat (8) step();
      if (iss_a.size() >= 1 && del_pc.size() >= 1) begin
         check("t6_iss0", iss_a[0], 8'h00);
         check("t6_pc0", del_pc[0], 8'h00);
         check("t6_latency", del_t[0] - iss_t[0], 2);
      end else check("t6_restart", 0, 1);

      // Randomized traffic against the stream model
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      do_reset(1'b1, 1'b1);
      repeat (400) begin
         fetch_en    = ($urandom % 8) != 0;
         if_ready    = ($urandom % 3) != 0;
         redirect    = ($urandom % 25) == 0;
         redirect_pc = 8'($urandom);
         step();
      end
      redirect = 1'b0;
      check("rand_progress", del_pc.size() > 60, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
